// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for the bus-based 32-bit RISC core: steps fetch and
// execute in T-states and decodes every datapath strobe from the current state and opcode.
module control_sequencer #(
  parameter int          OPC_W   = 5,
  parameter logic [3:0]  ALU_ADD = 4'b0011,
  parameter logic [3:0]  ALU_SUB = 4'b0100,
  parameter logic [3:0]  ALU_AND = 4'b0101,
  parameter logic [3:0]  ALU_OR  = 4'b0110
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] ir,
  input  logic        stop,
  output logic        run,
  output logic        gra,
  output logic        grb,
  output logic        grc,
  output logic        r_in,
  output logic        r_out,
  output logic        ba_out,
  output logic        pc_in,
  output logic        pc_out,
  output logic        ir_in,
  output logic        mar_in,
  output logic        mdr_in,
  output logic        mdr_out,
  output logic        y_in,
  output logic        z_in,
  output logic        z_low_out,
  output logic        c_out,
  output logic        inc_pc,
  output logic        hi_in,
  output logic        hi_out,
  output logic        lo_in,
  output logic        lo_out,
  output logic        z_high_out,
  output logic        inport_out,
  output logic        read,
  output logic        write,
  output logic [3:0]  alu_op
);

  localparam logic [OPC_W-1:0] OP_LD   = OPC_W'(5'b00000);
  localparam logic [OPC_W-1:0] OP_LDI  = OPC_W'(5'b00001);
  localparam logic [OPC_W-1:0] OP_ST   = OPC_W'(5'b00010);
  localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(5'b00011);
  localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(5'b00100);
  localparam logic [OPC_W-1:0] OP_AND  = OPC_W'(5'b00101);
  localparam logic [OPC_W-1:0] OP_OR   = OPC_W'(5'b00110);
  localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(5'b01100);
  localparam logic [OPC_W-1:0] OP_HALT = OPC_W'(5'b11011);

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4,
    S_E1, S_E2, S_E3, S_E4, S_E5, S_E6, S_HALT
  } state_e;

  state_e           state_q;
  logic [OPC_W-1:0] opc_q;
  logic [OPC_W-1:0] ir_opc;

  assign ir_opc = ir[31 -: OPC_W];

  // NOTE: sequential state uses non-blocking assignments only, and the asynchronous
  // reset sits in the sensitivity list so RESET is forced without waiting for a clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_RESET;
      opc_q   <= '0;
    end else begin
      case (state_q)
        S_RESET: state_q <= S_T0;
        S_T0:    state_q <= stop ? S_HALT : S_T1;
        S_T1:    state_q <= S_T2;
        S_T2:    state_q <= S_T3;
        S_T3:    state_q <= S_T4;
        S_T4: begin
          opc_q <= ir_opc;
          case (ir_opc)
            OP_HALT: state_q <= S_HALT;
            OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI:
              state_q <= S_E1;
            default: state_q <= S_T0;  // nop and unassigned opcodes
          endcase
        end
        S_E1:    state_q <= S_E2;
        S_E2:    state_q <= S_E3;
        S_E3:    state_q <= (opc_q == OP_LD || opc_q == OP_ST) ? S_E4 : S_T0;
        S_E4:    state_q <= S_E5;
        S_E5:    state_q <= (opc_q == OP_LD) ? S_E6 : S_T0;
        S_E6:    state_q <= S_T0;
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_RESET;
      endcase
    end
  end

  logic is_mem;
  logic is_addi;
  logic [3:0] rr_alu;

  assign is_mem  = (opc_q == OP_LD) || (opc_q == OP_LDI) || (opc_q == OP_ST);
  assign is_addi = (opc_q == OP_ADDI);

  always_comb begin
    case (opc_q)
      OP_SUB:  rr_alu = ALU_SUB;
      OP_AND:  rr_alu = ALU_AND;
      OP_OR:   rr_alu = ALU_OR;
      default: rr_alu = ALU_ADD;
    endcase
  end

  assign hi_in      = 1'b0;
  assign hi_out     = 1'b0;
  assign lo_in      = 1'b0;
  assign lo_out     = 1'b0;
  assign z_high_out = 1'b0;
  assign inport_out = 1'b0;

  // NOTE: every output gets a default before the case, so no state can infer a latch.
  always_comb begin
    run = 1'b0; gra = 1'b0; grb = 1'b0; grc = 1'b0;
    r_in = 1'b0; r_out = 1'b0; ba_out = 1'b0;
    pc_in = 1'b0; pc_out = 1'b0; ir_in = 1'b0; mar_in = 1'b0;
    mdr_in = 1'b0; mdr_out = 1'b0; y_in = 1'b0; z_in = 1'b0;
    z_low_out = 1'b0; c_out = 1'b0; inc_pc = 1'b0;
    read = 1'b0; write = 1'b0; alu_op = 4'b0000;
    run = (state_q != S_RESET) && (state_q != S_HALT);
    case (state_q)
      S_T0: begin
        pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; alu_op = ALU_ADD; z_in = 1'b1;
      end
      S_T1: begin z_low_out = 1'b1; pc_in = 1'b1; end
      S_T2: begin read = 1'b1; mdr_in = 1'b1; end
      S_T3: begin mdr_out = 1'b1; ir_in = 1'b1; end
      S_E1: begin
        grb = 1'b1; r_out = 1'b1; y_in = 1'b1; ba_out = is_mem;
      end
      S_E2: begin
        z_in = 1'b1;
        if (is_mem || is_addi) begin
          c_out = 1'b1; alu_op = ALU_ADD;
        end else begin
          grc = 1'b1; r_out = 1'b1; alu_op = rr_alu;
        end
      end
      S_E3: begin
        z_low_out = 1'b1;
        if (opc_q == OP_LD || opc_q == OP_ST) begin
          mar_in = 1'b1;
        end else begin
          gra = 1'b1; r_in = 1'b1;
        end
      end
      S_E4: begin
        if (opc_q == OP_ST) begin
          gra = 1'b1; r_out = 1'b1; mdr_in = 1'b1;
        end
      end
      S_E5: begin
        if (opc_q == OP_LD) begin
          read = 1'b1; mdr_in = 1'b1;
        end else begin
          write = 1'b1;
        end
      end
      S_E6: begin mdr_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: walks each instruction class cycle by cycle and
// compares the full control word against hand-written expected vectors.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] ir;
  logic        stop;
  logic run, gra, grb, grc, r_in, r_out, ba_out, pc_in, pc_out, ir_in, mar_in;
  logic mdr_in, mdr_out, y_in, z_in, z_low_out, c_out, inc_pc;
  logic hi_in, hi_out, lo_in, lo_out, z_high_out, inport_out, read, write;
  logic [3:0] alu_op;

  int n_pass  = 0;
  int n_check = 0;

  always #5 clk = ~clk;

  control_sequencer dut (
    .clk(clk), .reset_n(reset_n), .ir(ir), .stop(stop), .run(run),
    .gra(gra), .grb(grb), .grc(grc), .r_in(r_in), .r_out(r_out), .ba_out(ba_out),
    .pc_in(pc_in), .pc_out(pc_out), .ir_in(ir_in), .mar_in(mar_in), .mdr_in(mdr_in),
    .mdr_out(mdr_out), .y_in(y_in), .z_in(z_in), .z_low_out(z_low_out), .c_out(c_out),
    .inc_pc(inc_pc), .hi_in(hi_in), .hi_out(hi_out), .lo_in(lo_in), .lo_out(lo_out),
    .z_high_out(z_high_out), .inport_out(inport_out), .read(read), .write(write),
    .alu_op(alu_op)
  );

  // Control word bit positions; alu_op occupies [3:0].
  localparam logic [29:0] RUN    = 30'd1 << 29;
  localparam logic [29:0] GRA    = 30'd1 << 28;
  localparam logic [29:0] GRB    = 30'd1 << 27;
  localparam logic [29:0] GRC    = 30'd1 << 26;
  localparam logic [29:0] RIN    = 30'd1 << 25;
  localparam logic [29:0] ROUT   = 30'd1 << 24;
  localparam logic [29:0] BA     = 30'd1 << 23;
  localparam logic [29:0] PCIN   = 30'd1 << 22;
  localparam logic [29:0] PCOUT  = 30'd1 << 21;
  localparam logic [29:0] IRIN   = 30'd1 << 20;
  localparam logic [29:0] MARIN  = 30'd1 << 19;
  localparam logic [29:0] MDRIN  = 30'd1 << 18;
  localparam logic [29:0] MDROUT = 30'd1 << 17;
  localparam logic [29:0] YIN    = 30'd1 << 16;
  localparam logic [29:0] ZIN    = 30'd1 << 15;
  localparam logic [29:0] ZLO    = 30'd1 << 14;
  localparam logic [29:0] COUT   = 30'd1 << 13;
  localparam logic [29:0] INCPC  = 30'd1 << 12;
  localparam logic [29:0] READ   = 30'd1 << 5;
  localparam logic [29:0] WRITE  = 30'd1 << 4;
  localparam logic [29:0] NONE   = 30'd0;

  localparam logic [29:0] V_T0 = RUN | PCOUT | MARIN | INCPC | ZIN | 30'h3;
  localparam logic [29:0] V_T1 = RUN | ZLO | PCIN;
  localparam logic [29:0] V_T2 = RUN | READ | MDRIN;
  localparam logic [29:0] V_T3 = RUN | MDROUT | IRIN;
  localparam logic [29:0] V_T4 = RUN;
  localparam logic [29:0] RR_E1 = RUN | GRB | ROUT | YIN;
  localparam logic [29:0] RR_E2 = RUN | GRC | ROUT | ZIN;
  localparam logic [29:0] WB_E3 = RUN | ZLO | GRA | RIN;
  localparam logic [29:0] AI_E2 = RUN | COUT | ZIN | 30'h3;
  localparam logic [29:0] AD_E1 = RUN | GRB | ROUT | BA | YIN;
  localparam logic [29:0] MA_E3 = RUN | ZLO | MARIN;

  logic [29:0] obs;
  assign obs = {run, gra, grb, grc, r_in, r_out, ba_out, pc_in, pc_out, ir_in, mar_in,
                mdr_in, mdr_out, y_in, z_in, z_low_out, c_out, inc_pc, hi_in, hi_out,
                lo_in, lo_out, z_high_out, inport_out, read, write, alu_op};

  task automatic check(input string tag, input logic [29:0] exp);
    n_check++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expects T0 to be the current state on entry; leaves DECODE current on exit.
  task automatic fetch(input string name, input logic [4:0] opc);
    ir = {opc, 27'h2A5A5A5};
    check({name, " T0"}, V_T0); step();
    check({name, " T1"}, V_T1); step();
    check({name, " T2"}, V_T2); step();
    check({name, " T3"}, V_T3); step();
    check({name, " T4"}, V_T4);
  endtask

  task automatic run_instr(input string name, input logic [4:0] opc, input int n,
                           input logic [29:0] e1, input logic [29:0] e2,
                           input logic [29:0] e3, input logic [29:0] e4,
                           input logic [29:0] e5, input logic [29:0] e6,
                           input bit stop_e2);
    logic [29:0] ex [6];
    ex = '{e1, e2, e3, e4, e5, e6};
    fetch(name, opc);
    for (int i = 0; i < n; i++) begin
      step();
      if (stop_e2 && i == 1) stop = 1'b1;
      if (i == 2) stop = 1'b0;
      check($sformatf("%s E%0d", name, i + 1), ex[i]);
    end
    step();
    check({name, " return T0"}, V_T0);
  endtask

  initial begin
    reset_n = 1'b0;
    stop    = 1'b0;
    ir      = 32'h0;
    #3;
    check("reset idle", NONE);
    step(); step();
    check("reset held", NONE);
    reset_n = 1'b1;
    step();

    run_instr("add",  5'b00011, 3, RR_E1, RR_E2 | 30'h3, WB_E3, NONE, NONE, NONE, 1'b0);
    run_instr("sub",  5'b00100, 3, RR_E1, RR_E2 | 30'h4, WB_E3, NONE, NONE, NONE, 1'b0);
    run_instr("and",  5'b00101, 3, RR_E1, RR_E2 | 30'h5, WB_E3, NONE, NONE, NONE, 1'b1);
    run_instr("or",   5'b00110, 3, RR_E1, RR_E2 | 30'h6, WB_E3, NONE, NONE, NONE, 1'b0);
    run_instr("addi", 5'b01100, 3, RR_E1, AI_E2, WB_E3, NONE, NONE, NONE, 1'b0);
    run_instr("ldi",  5'b00001, 3, AD_E1, AI_E2, WB_E3, NONE, NONE, NONE, 1'b0);
    run_instr("ld",   5'b00000, 6, AD_E1, AI_E2, MA_E3, RUN, RUN | READ | MDRIN,
              RUN | MDROUT | GRA | RIN, 1'b0);
    run_instr("st",   5'b00010, 5, AD_E1, AI_E2, MA_E3, RUN | GRA | ROUT | MDRIN,
              RUN | WRITE, NONE, 1'b0);
    run_instr("nop",  5'b11010, 0, NONE, NONE, NONE, NONE, NONE, NONE, 1'b0);
    run_instr("unk",  5'b10101, 0, NONE, NONE, NONE, NONE, NONE, NONE, 1'b0);

    // Reset asserted between edges in the middle of a fetch.
    ir = {5'b00000, 27'h0};
    step(); step();
    #1 reset_n = 1'b0;
    #1 check("async reset", NONE);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("reset hold %0d", i), NONE);
    end
    reset_n = 1'b1;
    step();
    check("post-reset T0", V_T0);

    stop = 1'b1;
    step();
    check("stop in T0", NONE);
    stop = 1'b0;
    step();
    check("halt via stop held", NONE);
    reset_n = 1'b0;
    #2 reset_n = 1'b1;
    step();

    fetch("halt", 5'b11011);
    for (int i = 0; i < 22; i++) begin
      step();
      check($sformatf("halt cycle %0d", i), NONE);
    end

    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

endmodule
